keyboard_ctl: RTL
=================

# keyboard_ctl

Player-input front end that turns the decoded PS/2 keyboard byte stream into the level-held `jump`, `left`, `right` and `start_game` controls consumed by `movement`. It runs the make/break/extended-prefix protocol, debounces typematic repeats, arbitrates simultaneous left/right, and drops stale prefixes. It sits between the PS/2 byte receiver and `movement` in the 65 MHz domain. In simulation it replaces the scripted input driver.

## Interface
- `TIMEOUT_CYC`, 65_000, cycles a prefix (E0/F0) may wait for its follow-up byte before being discarded (1 ms at 65 MHz).
- `clk`  in  1  system clock, 65 MHz.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received scancode byte.
- `rx_valid`  in  1  one-cycle strobe; `rx_data` is valid this cycle.
- `jump`  out  1  high while Up arrow (E0 75) or Space (29) is held.
- `left`  out  1  high while Left arrow (E0 6B) is held and wins arbitration.
- `right`  out  1  high while Right arrow (E0 74) is held and wins arbitration.
- `start_game`  out  1  set by an Enter make (5A); sticky until reset.

## Operation
- Decoder FSM states are `IDLE`, `EXT` (got E0), `BRK` (got F0), `EXT_BRK` (got E0 F0).
  - `IDLE`: E0 goes to `EXT`. F0 goes to `BRK`. Any other byte is a make of a non-extended code, then stay in `IDLE`.
  - `EXT`: F0 goes to `EXT_BRK`. Any other byte is an extended make, then go to `IDLE`.
  - `BRK`: any byte is a non-extended break, then go to `IDLE`.
  - `EXT_BRK`: any byte is an extended break, then go to `IDLE`.
- Control bytes AA, FA, EE and FE are ignored in every state, and the FSM returns to `IDLE`.
- Error bytes 00 and FF clear all held-key flags and return the FSM to `IDLE`. They do not clear `start_game`.
- E0 received in `EXT`, or F0 received in `BRK`/`EXT_BRK`, is ignored; the state is unchanged and the timeout restarts.
- Held flags are `up_h`, `space_h`, `left_h` and `right_h`.
  - A make sets its flag and a break clears it.
  - A repeated make of an already-held key (typematic) changes nothing.
  - Unmapped codes are decoded fully and then discarded.
- `last_dir` is set to LEFT on a make of Left and to RIGHT on a make of Right, even when that make is a repeat.
- Output equations:
  - `jump` = `up_h | space_h`.
  - `left` = `left_h & (~right_h | last_dir==LEFT)`.
  - `right` = `right_h & (~left_h | last_dir==RIGHT)`.
  - Consequence: `left` and `right` are never both high. On release of the winning key, the other key, if still held, asserts.
- Timeout:
  - The counter runs only in `EXT`, `BRK` and `EXT_BRK`, and restarts on every accepted byte.
  - When it reaches `TIMEOUT_CYC-1` with no `rx_valid`, the FSM returns to `IDLE` and discards the pending prefix.
  - Counter width is `$clog2(TIMEOUT_CYC)`.

## Timing
- Every output is low after reset, and the FSM is in `IDLE` with `last_dir`=LEFT and the counter at 0.
- Latency: the final byte of a sequence is sampled on edge N, and the outputs change after edge N+1. There is one register stage for the decoded event and one for the outputs, and no combinational path from `rx_data`.
- Back-to-back `rx_valid` every cycle is fully supported; there is no backpressure.
- `rx_valid` on the same cycle the timeout expires: the byte wins and is decoded in the current state.
- Reset asserted mid-sequence forces everything to its reset value immediately, asynchronously.

## Structure
- `keyboard_pkg` holds:
  - the FSM state enum;
  - the direction enum;
  - scancode constants: `SC_EXT`=E0, `SC_BRK`=F0, `SC_UP`=75, `SC_LEFT`=6B, `SC_RIGHT`=74, `SC_SPACE`=29, `SC_ENTER`=5A;
  - the control and error byte constants.
- Sub-module `scancode_fsm` contains the prefix FSM and the timeout counter. It emits a registered one-cycle `ev_valid` with `ev_code[7:0]`, `ev_ext` and `ev_break`, plus `ev_flush` for error bytes.
- `keyboard_ctl` instantiates `scancode_fsm` and contains the held flags, `last_dir`, the sticky `start_game` and the output registers.

## Test plan
- Bytes E0 6B → `left`=1 two cycles after the 6B strobe. Then E0 F0 6B → `left`=0.
- Hold Left (E0 6B), then Right (E0 74) → `right`=1, `left`=0. Break Right (E0 F0 74) → `left`=1 again, with no cycle where both are high.
- 29 sent 10 times back-to-back, then F0 29 → `jump` is 1 from the first make until the break; the repeats cause no glitch.
- E0 followed by idle for `TIMEOUT_CYC` cycles, then 6B → interpreted as a non-extended 6B, so `left` stays 0. Repeat with the 6B arriving on the expiry cycle → `left`=1.
- Hold Up and Right, then send FF → `jump`=0 and `right`=0. Send 5A before the FF → `start_game` stays 1.
- Assert `rst`=0 between E0 and F0 → all outputs 0 at once. After release, F0 74 is decoded as a non-extended break and has no effect.

Source files
------------

// File: rtl/keyboard_pkg.sv
// Shared types and scancode constants for the PS/2 player-input front end.
// Covers decoder states, key direction, scancodes and key-slot helpers.
package keyboard_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } kb_state_t;

  typedef enum logic {
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;

  localparam logic [7:0] SC_ERR_LO = 8'h00;
  localparam logic [7:0] SC_ERR_HI = 8'hFF;

  // Slots of the held-key vector.
  localparam int NUM_KEYS  = 4;
  localparam int KEY_UP    = 0;
  localparam int KEY_SPACE = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;

  function automatic logic is_control(input logic [7:0] b);
    return (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO) || (b == SC_RESEND);
  endfunction

  function automatic logic is_error(input logic [7:0] b);
    return (b == SC_ERR_LO) || (b == SC_ERR_HI);
  endfunction

  function automatic logic [7:0] key_code(input int idx);
    logic [7:0] code;
    case (idx)
      KEY_UP:    code = SC_UP;
      KEY_SPACE: code = SC_SPACE;
      KEY_LEFT:  code = SC_LEFT;
      default:   code = SC_RIGHT;
    endcase
    return code;
  endfunction

  function automatic logic key_ext(input int idx);
    return idx != KEY_SPACE;
  endfunction

endpackage

// File: rtl/keyboard_if.sv
// Byte stream from the PS/2 receiver: a one-cycle strobe with its data byte.
interface keyboard_if;

  logic [7:0] rx_data;
  logic       rx_valid;

  modport master (
    output rx_data,
    output rx_valid
  );

  modport slave (
    input rx_data,
    input rx_valid
  );

endinterface

// File: rtl/scancode_fsm.sv
// Make/break/extended prefix decoder with stale-prefix timeout.
// Emits one registered event per completed scancode, or a flush on error bytes.
module scancode_fsm
  import keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65_000
) (
  input  logic       clk,
  input  logic       rst,
  keyboard_if.slave  rx,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic       ev_flush
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  kb_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ev_valid_reg, ev_valid_next;
  logic [7:0]       ev_code_reg, ev_code_next;
  logic             ev_ext_reg, ev_ext_next;
  logic             ev_break_reg, ev_break_next;
  logic             ev_flush_reg, ev_flush_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      ev_valid_reg <= 1'b0;
      ev_code_reg  <= '0;
      ev_ext_reg   <= 1'b0;
      ev_break_reg <= 1'b0;
      ev_flush_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      ev_valid_reg <= ev_valid_next;
      ev_code_reg  <= ev_code_next;
      ev_ext_reg   <= ev_ext_next;
      ev_break_reg <= ev_break_next;
      ev_flush_reg <= ev_flush_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    ev_valid_next = 1'b0;
    ev_code_next  = ev_code_reg;
    ev_ext_next   = 1'b0;
    ev_break_next = 1'b0;
    ev_flush_next = 1'b0;

    if (rx.rx_valid) begin
      // A byte always wins over an expiring timeout and restarts the count.
      cnt_next     = '0;
      ev_code_next = rx.rx_data;
      if (is_error(rx.rx_data)) begin
        state_next    = IDLE;
        ev_flush_next = 1'b1;
      end else if (is_control(rx.rx_data)) begin
        state_next = IDLE;
      end else begin
        case (state_reg)
          IDLE: begin
            if (rx.rx_data == SC_EXT) begin
              state_next = EXT;
            end else if (rx.rx_data == SC_BRK) begin
              state_next = BRK;
            end else begin
              ev_valid_next = 1'b1;
            end
          end
          EXT: begin
            if (rx.rx_data == SC_BRK) begin
              state_next = EXT_BRK;
            end else if (rx.rx_data != SC_EXT) begin
              ev_valid_next = 1'b1;
              ev_ext_next   = 1'b1;
              state_next    = IDLE;
            end
          end
          BRK: begin
            if (rx.rx_data != SC_BRK) begin
              ev_valid_next = 1'b1;
              ev_break_next = 1'b1;
              state_next    = IDLE;
            end
          end
          EXT_BRK: begin
            if (rx.rx_data != SC_BRK) begin
              ev_valid_next = 1'b1;
              ev_ext_next   = 1'b1;
              ev_break_next = 1'b1;
              state_next    = IDLE;
            end
          end
          default: state_next = IDLE;
        endcase
      end
    end else if (state_reg != IDLE) begin
      if (cnt_reg == CNT_LAST) begin
        state_next = IDLE;
        cnt_next   = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  assign ev_valid = ev_valid_reg;
  assign ev_code  = ev_code_reg;
  assign ev_ext   = ev_ext_reg;
  assign ev_break = ev_break_reg;
  assign ev_flush = ev_flush_reg;

endmodule

// File: rtl/keyboard_ctl.sv
// Player-input front end: turns decoded scancode events into level-held
// jump/left/right controls and a sticky start_game flag.
module keyboard_ctl
  import keyboard_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65_000
) (
  input  logic      clk,
  input  logic      rst,
  keyboard_if.slave rx,
  output logic      jump,
  output logic      left,
  output logic      right,
  output logic      start_game
);

  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       ev_flush;

  scancode_fsm #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .ev_ext   (ev_ext),
    .ev_break (ev_break),
    .ev_flush (ev_flush)
  );

  logic [NUM_KEYS-1:0] key_hit;
  logic [NUM_KEYS-1:0] held_reg, held_next;
  dir_t                last_dir_reg, last_dir_next;
  logic                start_reg, start_next;
  logic                jump_reg, jump_next;
  logic                left_reg, left_next;
  logic                right_reg, right_next;

  // Typematic repeats rewrite the same value, so they leave the flag unchanged.
  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
    assign key_hit[gi]   = ev_valid && (ev_code == key_code(gi)) && (ev_ext == key_ext(gi));
    assign held_next[gi] = ev_flush ? 1'b0 : (key_hit[gi] ? ~ev_break : held_reg[gi]);
  end

  always_comb begin
    last_dir_next = last_dir_reg;
    start_next    = start_reg;
    if (key_hit[KEY_LEFT] && !ev_break) begin
      last_dir_next = DIR_LEFT;
    end else if (key_hit[KEY_RIGHT] && !ev_break) begin
      last_dir_next = DIR_RIGHT;
    end
    if (ev_valid && !ev_ext && !ev_break && (ev_code == SC_ENTER)) begin
      start_next = 1'b1;
    end
  end

  // The most recently pressed direction wins while both are held.
  always_comb begin
    jump_next  = held_next[KEY_UP] | held_next[KEY_SPACE];
    left_next  = held_next[KEY_LEFT] &
                 (~held_next[KEY_RIGHT] | (last_dir_next == DIR_LEFT));
    right_next = held_next[KEY_RIGHT] &
                 (~held_next[KEY_LEFT] | (last_dir_next == DIR_RIGHT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_reg     <= '0;
      last_dir_reg <= DIR_LEFT;
      start_reg    <= 1'b0;
      jump_reg     <= 1'b0;
      left_reg     <= 1'b0;
      right_reg    <= 1'b0;
    end else begin
      held_reg     <= held_next;
      last_dir_reg <= last_dir_next;
      start_reg    <= start_next;
      jump_reg     <= jump_next;
      left_reg     <= left_next;
      right_reg    <= right_next;
    end
  end

  assign jump       = jump_reg;
  assign left       = left_reg;
  assign right      = right_reg;
  assign start_game = start_reg;

endmodule
